// File: rtl/adder_tree_pkg.sv
// Shared defaults for the adder tree and its addend collector.
// Holds tree geometry, latency and the collector state type.
package adder_tree_pkg;

  localparam int ADD_LENGTH   = 16;
  localparam int NUM_ADDEND   = 15;
  localparam int TREE_LATENCY = $clog2(NUM_ADDEND) + 1;

  typedef enum logic {
    FILL,
    FULL
  } state_t;

endpackage

// File: rtl/addend_collector_if.sv
// Addend input stream: one word per cycle, valid/ready handshake.
// Last marks a short frame and is qualified by valid.
interface addend_collector_if #(
  parameter int W = 16
) ();

  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/valid_delay.sv
// Fixed-depth 1-bit delay line with asynchronous active-low clear.
// Used to align strobes with free-running pipelines.
module valid_delay #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr <= '0;
        else      sr <= d;
      end
    end else begin : g_many
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr <= '0;
        else      sr <= {sr[DEPTH-2:0], d};
      end
    end
  endgenerate

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/addend_collector.sv
// Packs a serial addend stream into frames for the adder tree,
// launches each frame and flags the cycle its sum appears.
module addend_collector #(
  parameter int ADD_LENGTH   = adder_tree_pkg::ADD_LENGTH,
  parameter int NUM_ADDEND   = adder_tree_pkg::NUM_ADDEND,
  parameter int TREE_LATENCY = adder_tree_pkg::TREE_LATENCY
) (
  input  logic                           clk,
  input  logic                           rst,
  addend_collector_if.slave              s,
  input  logic                           hold,
  output logic [ADD_LENGTH*NUM_ADDEND-1:0] addends,
  output logic                           launch,
  output logic                           sum_valid
);

  import adder_tree_pkg::*;

  localparam int IW = $clog2(NUM_ADDEND + 1);
  localparam int VW = ADD_LENGTH * NUM_ADDEND;

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   idx;
  logic [ADD_LENGTH-1:0] buf_q [NUM_ADDEND];
  logic [VW-1:0]   pack;
  logic [VW-1:0]   addends_q;
  logic            ready_q;
  logic            ready_nx;
  logic            launch_q;
  logic            accept;
  logic            done;
  logic            xfer;

  // ready_q is only ever high in FILL, so it also gates the state
  assign accept = s.in_valid && ready_q;
  assign done   = accept &&
                  (s.in_last || idx == IW'(NUM_ADDEND - 1));
  assign xfer   = (state == FULL) && !hold;

  always_comb begin
    state_nx = state;
    ready_nx = ready_q;
    unique case (state)
      FILL: begin
        if (done) begin
          state_nx = FULL;
          ready_nx = 1'b0;
        end else begin
          ready_nx = 1'b1;
        end
      end
      FULL: begin
        if (!hold) begin
          state_nx = FILL;
          ready_nx = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FILL;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_q <= ready_nx;
    end
  end

  always_comb begin
    pack = '0;
    for (int i = 0; i < NUM_ADDEND; i++)
      pack[ADD_LENGTH*i +: ADD_LENGTH] = buf_q[i];
  end

  // Clearing on transfer is what zero-fills short frames
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      addends_q <= '0;
      launch_q  <= 1'b0;
      for (int i = 0; i < NUM_ADDEND; i++)
        buf_q[i] <= '0;
    end else begin
      launch_q <= xfer;
      if (xfer) begin
        addends_q <= pack;
        idx       <= '0;
        for (int i = 0; i < NUM_ADDEND; i++)
          buf_q[i] <= '0;
      end else if (accept) begin
        buf_q[idx] <= s.in_data;
        idx        <= idx + IW'(1);
      end
    end
  end

  valid_delay #(
    .DEPTH(TREE_LATENCY)
  ) u_sum_dly (
    .clk(clk),
    .rst(rst),
    .d  (launch_q),
    .q  (sum_valid)
  );

  assign s.in_ready = ready_q;
  assign addends    = addends_q;
  assign launch     = launch_q;

endmodule

// File: doc/addend_collector.md
# addend_collector

Serial-to-parallel front end for the pipelined adder tree. It accepts addends one word per cycle over a valid/ready stream and packs each frame into slot order. When a frame is complete, it presents the frame as one stable parallel vector on the tree's wide `addends` bus. It also produces a `sum_valid` strobe marking the single cycle in which the tree's `sum` output corresponds to that vector, because the tree itself is free-running and carries no valid.

## Interface
- `ADD_LENGTH`, 16, width of one addend word (matches the tree).
- `NUM_ADDEND`, 15, slots per frame (matches the tree).
- `TREE_LATENCY`, 5, cycles from an `addends` change to the matching `sum`; equals `$clog2(NUM_ADDEND)+1`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  ADD_LENGTH  addend word.
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  current word ends the frame early; qualified by `in_valid`.
- `in_ready`  out  1  block accepts a word on this edge when `in_valid && in_ready`.
- `hold`  in  1  downstream stall; while high, no launch occurs.
- `addends`  out  ADD_LENGTH*NUM_ADDEND  packed vector; slot i is `[ADD_LENGTH*i +: ADD_LENGTH]`.
- `launch`  out  1  one-cycle pulse, high in the first cycle a new `addends` value is visible.
- `sum_valid`  out  1  high in exactly the cycle the tree's `sum` reflects the launched vector.

## Operation
- **FILL state**
  - Each accepted word is written to collect buffer slot `idx`, then `idx` is incremented.
  - `idx` width is `$clog2(NUM_ADDEND+1)`.
  - The frame completes when `idx == NUM_ADDEND-1` on accept, or when `in_last` is seen on accept. The block then goes to FULL and `in_ready` drops.
- **FULL state**
  - `in_ready` is 0; `in_valid` is ignored.
  - If `hold` is 0: `addends` takes the buffer, `launch` is set to 1, the buffer and `idx` clear to 0, the state returns to FILL, and `in_ready` is set to 1.
  - If `hold` is 1: the block stays in FULL; `addends` and the buffer are unchanged.
- **Zero-fill:** slots not written in a short frame read 0, because the buffer is cleared on every transfer and on reset.
- **`in_last` on slot `NUM_ADDEND-1`** behaves the same as no `in_last`.
- **`addends` stability:** `addends` changes only on a transfer, so the tree recomputes the same sum on every cycle in between.
- **`sum_valid`** is `launch` delayed by exactly `TREE_LATENCY` cycles through a shift register. Overlapping launches are all preserved.
- **Arithmetic:** there is none. Words pass through unmodified, with no sign or width conversion.

## Timing
- **Reset values** while `rst` is low: state FILL, `idx` 0, buffer 0, `addends` 0, `launch` 0, `in_ready` 0, `sum_valid` 0, delay line 0.
- **After release:** `in_ready` goes to 1 on the first rising edge with `rst` high.
- **Completing word:** the word accepted at edge E0 moves the state to FULL; `in_ready` is 0 after E0.
- **Transfer:** occurs at the first edge E1 after E0 with `hold` low. `addends` and `launch` are valid after E1, and `in_ready` is 1 again after E1.
- **Throughput:**
  - The minimum frame period is (words in frame)+1 cycles, so a full frame takes NUM_ADDEND+1 cycles.
  - Single-word frames launch every 2 cycles.
- **`sum_valid`:** asserted in the cycle TREE_LATENCY cycles after the `launch` cycle.
- **Reset mid-operation:** all of the following are lost:
  - any partial frame;
  - a FULL buffer;
  - pending `sum_valid` bits.

  No spurious `launch` or `sum_valid` pulse occurs after release.
- **`hold` changes:** `hold` may change in any cycle; it is sampled only in FULL.

## Structure
- **Shared package `adder_tree_pkg`:**
  - default `ADD_LENGTH`, `NUM_ADDEND`, `TREE_LATENCY`;
  - the state type with values FILL and FULL.

  The tree and this block take their defaults from it.
- **Sub-module `valid_delay`:** a parameterised-depth 1-bit shift register with asynchronous active-low clear. It produces `sum_valid` and is reusable for other latency-matched strobes.

## Test plan
- **Reset:** hold `rst` low for 3 cycles with `in_valid=1`.
  - During reset, all outputs are 0 and nothing is accepted.
  - `in_ready` is 1 after the first edge following release.
- **Full frame:** words 1..15 sent back-to-back with `hold=0`.
  - `in_ready` is low for 1 cycle.
  - `launch` pulses once, with slot i = i+1.
  - `sum_valid` is high 5 cycles later, when the tree's `sum` is 120.
- **Short frame:** words 7, 8, 9 with `in_last` on the 9.
  - Slots 0..2 are 7, 8, 9 and slots 3..14 are 0.
  - `sum_valid` coincides with `sum` = 24.
- **Stall:** `hold=1` from frame completion for 10 cycles.
  - No `launch`; `in_ready` is 0 and `addends` is unchanged.
  - `hold` falls, then the transfer happens on the next edge.
  - A word offered during the stall is not consumed.
- **Back-to-back single-word frames:** `in_last` on every word, values 5, 6, 7.
  - `launch` occurs every 2 cycles.
  - `sum_valid` produces 3 pulses spaced 2 cycles apart, paired with sums 5, 6, 7.
- **Reset mid-flight:** assert reset after 6 words of a frame and 2 cycles after a launch.
  - After release, no `sum_valid` pulse appears.
  - The next word lands in slot 0.
